// File: rtl/data_mem_lsu_rv32i_if.sv
// Request/response bundle between the MEM stage and the data memory LSU.
// master drives req_valid/we/funct3/addr/wdata; slave returns ready and rsp_*.
interface data_mem_lsu_rv32i_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_lsu_rv32i.sv
// RV32I data RAM with load/store front end, lane stores, fault check, clear.
// Ports: clk, rst_n (async low), bus (slave modport: req_* in, rsp_* out).
module data_mem_lsu_rv32i #(
  parameter int ADDR_W     = 10,
  parameter int READ_LAT   = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic clk,
  input  logic rst_n,
  data_mem_lsu_rv32i_if.slave bus
);
  localparam int WIDX_W = ADDR_W - 2;
  localparam int DEPTH  = 1 << WIDX_W;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [WIDX_W-1:0] cnt_q, cnt_d;
  logic              ready;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (INIT_CLEAR != 0) ? S_INIT : S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WIDX_W'(DEPTH - 1))
          state_d = S_RUN;
      end
      S_RUN: ready = 1'b1;
      default: state_d = S_RUN;
    endcase
  end

  assign bus.req_ready = ready;

  logic              accept, bad_f3, misalign, err, wr;
  logic [2:0]        f3;
  logic [1:0]        off;
  logic [WIDX_W-1:0] widx;
  logic [3:0]        be;
  logic [31:0]       wlane;

  assign accept = bus.req_valid && ready;
  assign f3     = bus.req_funct3;
  assign off    = bus.req_addr[1:0];
  assign widx   = bus.req_addr[ADDR_W-1:2];

  // 011/11x are undefined; BU/HU have no store form.
  assign bad_f3 = (f3 == 3'b011) || (f3[2:1] == 2'b11)
               || (bus.req_we && f3[2]);
  assign misalign = ((f3[1:0] == 2'b01) && off[0])
                 || ((f3[1:0] == 2'b10) && (off != 2'b00));
  assign err = bad_f3 || misalign;
  assign wr  = accept && bus.req_we && !err;

  always_comb begin
    be    = 4'b1111;
    wlane = bus.req_wdata;
    unique case (1'b1)
      (f3[1:0] == 2'b00): begin
        be    = 4'b0001 << off;
        wlane = {4{bus.req_wdata[7:0]}};
      end
      (f3[1:0] == 2'b01): begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wlane = {2{bus.req_wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem[cnt_q] <= '0;
    end else if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
    end
  end

  // Stage 1 only loads on acceptance so the response holds when idle.
  logic        v1_q, err1_q, ld1_q;
  logic [2:0]  f3_1_q;
  logic [1:0]  off1_q;
  logic [31:0] word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      err1_q <= 1'b0;
      ld1_q  <= 1'b0;
      f3_1_q <= '0;
      off1_q <= '0;
      word_q <= '0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        err1_q <= err;
        ld1_q  <= !bus.req_we && !err;
        f3_1_q <= f3;
        off1_q <= off;
        word_q <= mem[widx];
      end
    end
  end

  logic [31:0] ext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sx;

  assign byte_v = word_q[8*off1_q +: 8];
  assign half_v = off1_q[1] ? word_q[31:16] : word_q[15:0];
  assign sx     = ~f3_1_q[2];

  always_comb begin
    ext = '0;
    if (ld1_q) begin
      unique case (1'b1)
        (f3_1_q[1:0] == 2'b00):
          ext = {{24{sx & byte_v[7]}}, byte_v};
        (f3_1_q[1:0] == 2'b01):
          ext = {{16{sx & half_v[15]}}, half_v};
        default: ext = word_q;
      endcase
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic        v2_q, e2_q;
    logic [31:0] d2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_q <= 1'b0;
        e2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          e2_q <= err1_q;
          d2_q <= ext;
        end
      end
    end

    assign bus.rsp_valid = v2_q;
    assign bus.rsp_rdata = d2_q;
    assign bus.rsp_err   = e2_q;
  end else begin : g_lat1
    assign bus.rsp_valid = v1_q;
    assign bus.rsp_rdata = ext;
    assign bus.rsp_err   = err1_q;
  end
endmodule

// File: tb/tb_data_mem_lsu_rv32i.sv
// Bench: twin instances (READ_LAT 1 and 2) fed identical requests.
// Expected responses are queued on drive and checked by per-DUT monitors.
module tb_data_mem_lsu_rv32i;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  data_mem_lsu_rv32i_if #(.ADDR_W(10)) b1 ();
  data_mem_lsu_rv32i_if #(.ADDR_W(10)) b2 ();

  assign b2.req_valid  = b1.req_valid;
  assign b2.req_we     = b1.req_we;
  assign b2.req_funct3 = b1.req_funct3;
  assign b2.req_addr   = b1.req_addr;
  assign b2.req_wdata  = b1.req_wdata;

  data_mem_lsu_rv32i #(
    .ADDR_W(10), .READ_LAT(1), .INIT_CLEAR(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave)
  );

  data_mem_lsu_rv32i #(
    .ADDR_W(10), .READ_LAT(2), .INIT_CLEAR(1)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave)
  );

  always @(negedge clk) begin : mon1
    exp_t e;
    if (b1.rsp_valid === 1'b1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL rsp1_extra d=%h e=%b cyc=%0d",
                 b1.rsp_rdata, b1.rsp_err, cyc);
      end else begin
        e = q1.pop_front();
        if (b1.rsp_rdata !== e.d || b1.rsp_err !== e.e
            || cyc !== e.c) begin
          bad++;
          $display("FAIL rsp1 got d=%h e=%b cyc=%0d want d=%h e=%b cyc=%0d",
                   b1.rsp_rdata, b1.rsp_err, cyc, e.d, e.e, e.c);
        end
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (b2.rsp_valid === 1'b1) begin
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("FAIL rsp2_extra d=%h e=%b cyc=%0d",
                 b2.rsp_rdata, b2.rsp_err, cyc);
      end else begin
        e = q2.pop_front();
        if (b2.rsp_rdata !== e.d || b2.rsp_err !== e.e
            || cyc !== e.c) begin
          bad++;
          $display("FAIL rsp2 got d=%h e=%b cyc=%0d want d=%h e=%b cyc=%0d",
                   b2.rsp_rdata, b2.rsp_err, cyc, e.d, e.e, e.c);
        end
      end
    end
  end

  // Called at a negedge; request is accepted at the next posedge.
  task automatic send(input logic we, input logic [2:0] f3,
                      input logic [9:0] a, input logic [31:0] wd,
                      input logic [31:0] d, input logic e);
    b1.req_valid  = 1'b1;
    b1.req_we     = we;
    b1.req_funct3 = f3;
    b1.req_addr   = a;
    b1.req_wdata  = wd;
    q1.push_back('{d, e, cyc + 1});
    q2.push_back('{d, e, cyc + 2});
    @(negedge clk);
    b1.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    b1.req_valid  = 1'b0;
    b1.req_we     = 1'b0;
    b1.req_funct3 = 3'b000;
    b1.req_addr   = '0;
    b1.req_wdata  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (b1.req_ready !== 1'b0 || b1.rsp_valid !== 1'b0
        || b1.rsp_rdata !== 32'h0 || b1.rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset1 rdy=%b v=%b d=%h e=%b want 0 0 0 0",
               b1.req_ready, b1.rsp_valid, b1.rsp_rdata, b1.rsp_err);
    end
    total++;
    if (b2.req_ready !== 1'b0 || b2.rsp_valid !== 1'b0
        || b2.rsp_rdata !== 32'h0 || b2.rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset2 rdy=%b v=%b d=%h e=%b want 0 0 0 0",
               b2.req_ready, b2.rsp_valid, b2.rsp_rdata, b2.rsp_err);
    end
  endtask

  task automatic test_init_time(input string tag);
    int n = 0;
    rst_n = 1'b1;
    while (b1.req_ready !== 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n != 256) begin
      bad++;
      $display("FAIL %s_ready_low cycles=%0d want 256", tag, n);
    end
    total++;
    if (b2.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready2 got %b want 1", tag, b2.req_ready);
    end
  endtask

  task automatic test_init_clear();
    for (int i = 0; i < 256; i++)
      send(1'b0, 3'b010, 10'(i * 4), 32'h0, 32'h0, 1'b0);
    wait_drain();
    total++;
    if (q1.size() + q2.size() != 0) begin
      bad++;
      $display("FAIL init_drain left=%0d want 0", q1.size() + q2.size());
      q1.delete();
      q2.delete();
    end
  endtask

  task automatic test_lanes();
    logic [31:0] sb_e[4];
    logic [31:0] ub_e[4];
    sb_e = '{32'hFFFFFFBB, 32'hFFFFFFAA, 32'hFFFFFF99, 32'hFFFFFF88};
    ub_e = '{32'h000000BB, 32'h000000AA, 32'h00000099, 32'h00000088};
    send(1'b1, 3'b010, 10'h010, 32'h8899AABB, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 3'b000, 10'(16 + i), 32'h0, sb_e[i], 1'b0);
      send(1'b0, 3'b100, 10'(16 + i), 32'h0, ub_e[i], 1'b0);
    end
    send(1'b0, 3'b001, 10'h012, 32'h0, 32'hFFFF8899, 1'b0);
    send(1'b0, 3'b101, 10'h012, 32'h0, 32'h00008899, 1'b0);
    wait_drain();
    total++;
    if (q1.size() + q2.size() != 0) begin
      bad++;
      $display("FAIL lanes_drain left=%0d want 0", q1.size() + q2.size());
      q1.delete();
      q2.delete();
    end
    repeat (3) @(negedge clk);
    total++;
    if (b1.rsp_rdata !== 32'h00008899 || b1.rsp_err !== 1'b0
        || b2.rsp_rdata !== 32'h00008899 || b2.rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL hold got %h/%b %h/%b want 00008899/0",
               b1.rsp_rdata, b1.rsp_err, b2.rsp_rdata, b2.rsp_err);
    end
  endtask

  task automatic test_sb_sh();
    send(1'b1, 3'b010, 10'h020, 32'h11223344, 32'h0, 1'b0);
    send(1'b1, 3'b000, 10'h021, 32'h0000005A, 32'h0, 1'b0);
    send(1'b0, 3'b010, 10'h020, 32'h0, 32'h11225A44, 1'b0);
    send(1'b1, 3'b001, 10'h022, 32'h0000BEEF, 32'h0, 1'b0);
    send(1'b0, 3'b010, 10'h020, 32'h0, 32'hBEEF5A44, 1'b0);
    wait_drain();
    total++;
    if (q1.size() + q2.size() != 0) begin
      bad++;
      $display("FAIL sbsh_drain left=%0d want 0", q1.size() + q2.size());
      q1.delete();
      q2.delete();
    end
  endtask

  task automatic test_errors();
    send(1'b0, 3'b010, 10'h006, 32'h0, 32'h0, 1'b1);
    send(1'b0, 3'b001, 10'h003, 32'h0, 32'h0, 1'b1);
    send(1'b1, 3'b010, 10'h002, 32'hFFFFFFFF, 32'h0, 1'b1);
    send(1'b0, 3'b011, 10'h000, 32'h0, 32'h0, 1'b1);
    send(1'b1, 3'b100, 10'h000, 32'hFFFFFFFF, 32'h0, 1'b1);
    send(1'b1, 3'b111, 10'h000, 32'hFFFFFFFF, 32'h0, 1'b1);
    send(1'b0, 3'b010, 10'h000, 32'h0, 32'h0, 1'b0);
    wait_drain();
    total++;
    if (q1.size() + q2.size() != 0) begin
      bad++;
      $display("FAIL err_drain left=%0d want 0", q1.size() + q2.size());
      q1.delete();
      q2.delete();
    end
  endtask

  task automatic test_back_to_back();
    send(1'b1, 3'b010, 10'h040, 32'hCAFEF00D, 32'h0, 1'b0);
    send(1'b0, 3'b010, 10'h040, 32'h0, 32'hCAFEF00D, 1'b0);
    send(1'b0, 3'b010, 10'h044, 32'h0, 32'h0, 1'b0);
    wait_drain();
    total++;
    if (q1.size() + q2.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain left=%0d want 0", q1.size() + q2.size());
      q1.delete();
      q2.delete();
    end
  endtask

  task automatic test_reset_midflight();
    b1.req_valid  = 1'b1;
    b1.req_we     = 1'b0;
    b1.req_funct3 = 3'b010;
    b1.req_addr   = 10'h010;
    q1.push_back('{32'h8899AABB, 1'b0, cyc + 1});
    @(negedge clk);
    b1.req_addr = 10'h020;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    b1.req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (b1.rsp_valid !== 1'b0 || b2.rsp_valid !== 1'b0
        || b1.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst v1=%b v2=%b rdy=%b want 0 0 0",
               b1.rsp_valid, b2.rsp_valid, b1.req_ready);
    end
    total++;
    if (q1.size() != 0) begin
      bad++;
      $display("FAIL midrst_first left=%0d want 0", q1.size());
      q1.delete();
    end
    @(negedge clk);
    test_init_time("reinit");
    send(1'b0, 3'b010, 10'h010, 32'h0, 32'h0, 1'b0);
    wait_drain();
    total++;
    if (q1.size() + q2.size() != 0) begin
      bad++;
      $display("FAIL reinit_drain left=%0d want 0", q1.size() + q2.size());
      q1.delete();
      q2.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_time("init");
    test_init_clear();
    test_lanes();
    test_sb_sh();
    test_errors();
    test_back_to_back();
    test_reset_midflight();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_lsu_rv32i.md
Name: data_mem_lsu_rv32i

Overview:
Parametrised RV32I data memory with a load/store front end.
- Replaces the fixed 1-cycle byte-addressed data memory: the memory array is inferred internally, and depth and read latency are configurable.
- Adds a valid/ready request handshake, SB/SH/SW byte-lane stores, misalignment fault reporting, and a post-reset memory-clear sequence.
- Sits between the core's MEM stage and local data RAM.

Parameters:
ADDR_W, 10, byte-address width; memory holds 2**(ADDR_W-2) 32-bit words; legal range 4..16.
READ_LAT, 1, cycles from request acceptance to response; legal values 1 or 2.
INIT_CLEAR, 1, 1 = zero every word after reset before accepting requests; 0 = skip (contents undefined).

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; BU/HU with req_we=1 are illegal
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data; low bits used for B/H
rsp_valid  output  1  one-cycle response pulse, one per accepted request
rsp_rdata  output  32  load data, sign/zero-extended; 0 for stores and errors
rsp_err  output  1  misaligned access or illegal funct3; valid with rsp_valid

Behaviour:
- Reset: rst_n low asynchronously clears state to INIT (or IDLE if INIT_CLEAR=0), clears all pipeline valids, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0. Memory contents are not reset asynchronously.
- FSM:
  - INIT: counter walks word 0..DEPTH-1, writing 0, one word per cycle; req_ready=0. After the last word it goes to IDLE (DEPTH cycles total).
  - IDLE/RUN: req_ready=1 every cycle; no backpressure from the response side.
- Acceptance: req_valid && req_ready at a rising edge. One request per cycle; full throughput.
- Alignment rules:
  - H/HU need addr[0]=0; W needs addr[1:0]=00.
  - Violation, or funct3 in {011,110,111}, or BU/HU with req_we=1 gives rsp_err=1, rsp_rdata=0, and no memory write.
- Store: byte-lane write at the acceptance edge.
  - SB: lane addr[1:0] gets wdata[7:0].
  - SH: lanes {addr[1],0}+1:+0 get wdata[15:0].
  - SW: all four lanes.
  - Unselected lanes keep their value.
  - Response: rsp_valid with rdata=0, err=0, after READ_LAT cycles.
- Load:
  - Word read at the acceptance edge (word index addr[ADDR_W-1:2]).
  - Lane select and extension use the byte offset and funct3 carried down the pipeline.
  - B/H sign-extend; BU/HU zero-extend.
  - READ_LAT=2 adds an output register after extension.
- Latency: request accepted at edge N → rsp_valid high in the cycle after edge N+READ_LAT-1, i.e. visible just after edge N+READ_LAT-1 for READ_LAT=1, and one edge later for READ_LAT=2. Responses are in order, exactly one per request.
- Store followed by load to the same word in the next cycle: the load returns the stored data, with no stale read.
- Address wraps naturally within ADDR_W; no out-of-range case.
- rsp_rdata and rsp_err hold their last value when rsp_valid=0, except after reset (0).
- Reset asserted mid-operation: in-flight responses are dropped, never emitted; INIT restarts from word 0.

Test Plan:
1. Reset then INIT_CLEAR=1, ADDR_W=10 → req_ready low exactly 256 cycles; then LW 0x000..0x3FC all return 0x00000000, err=0.
2. SW 0x10 ← 0x8899AABB; then LB/LBU at 0x10..0x13 → 0xFFFFFFBB/0xBB, 0xFFFFFFAA/0xAA, 0xFFFFFF99/0x99, 0xFFFFFF88/0x88; LH/LHU at 0x12 → 0xFFFF8899/0x00008899.
3. SB 0x21 ← 0x5A over word 0x11223344 at 0x20 → LW 0x20 = 0x11225A44; SH 0x22 ← 0xBEEF → LW 0x20 = 0xBEEF5A44.
4. LW 0x06, LH 0x03, SW 0x02 ← 0xFFFFFFFF → each rsp_err=1, rdata=0; LW 0x00 afterwards unchanged.
5. READ_LAT=1 and 2: back-to-back SW 0x40 ← 0xCAFEF00D, LW 0x40, LW 0x44 on consecutive cycles → three rsp_valid pulses in order at acceptance+READ_LAT, second = 0xCAFEF00D.
6. Assert rst_n low while two loads are in flight → no rsp_valid pulse for them; req_ready=0 until INIT completes again.
